// File: rtl/ppu_vram_arbiter.sv
// PPU VRAM arbiter: shares one synchronous VRAM port between the renderer, a CPU
// write queue and a single outstanding CPU read.
// Priority each cycle: renderer > write-queue drain > pending CPU read.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   render_active_i          renderer owns the memory this cycle
//   ren_addr_i / ren_rdata_o renderer fetch address / read data (= mem_rdata_i)
//   cpu_wr_req_i, cpu_wr_addr_i, cpu_wr_data_i, cpu_wr_full_o   CPU write queue
//   cpu_rd_req_i, cpu_rd_addr_i, cpu_rd_busy_o, cpu_rd_valid_o, cpu_rd_data_o   CPU read
//   mem_addr_o, mem_we_o, mem_wdata_o, mem_rdata_i               VRAM port
//   wq_level_o               write-queue occupancy
//   err_overflow_o           sticky: write dropped because the queue was full
//   err_rd_collide_o         sticky: read requested while one was outstanding
module ppu_vram_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WQ_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      render_active_i,
  input  logic [ADDR_W-1:0]         ren_addr_i,
  output logic [DATA_W-1:0]         ren_rdata_o,
  input  logic                      cpu_wr_req_i,
  input  logic [ADDR_W-1:0]         cpu_wr_addr_i,
  input  logic [DATA_W-1:0]         cpu_wr_data_i,
  output logic                      cpu_wr_full_o,
  input  logic                      cpu_rd_req_i,
  input  logic [ADDR_W-1:0]         cpu_rd_addr_i,
  output logic                      cpu_rd_busy_o,
  output logic                      cpu_rd_valid_o,
  output logic [DATA_W-1:0]         cpu_rd_data_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic                      mem_we_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic [$clog2(WQ_DEPTH):0] wq_level_o,
  output logic                      err_overflow_o,
  output logic                      err_rd_collide_o
);

  localparam int unsigned PtrW = $clog2(WQ_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(WQ_DEPTH);

  typedef enum logic [1:0] {StIdle, StPend, StIssueWait} rd_state_e;

  // Write queue
  logic [ADDR_W-1:0] wq_addr_q [WQ_DEPTH];
  logic [DATA_W-1:0] wq_data_q [WQ_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              full, empty, push, pop;

  // Read path
  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_ovf_q, err_ovf_d, err_col_q, err_col_d;

  assign full  = (level_q == FullLvl);
  assign empty = (level_q == '0);
  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign push  = cpu_wr_req_i && !full;
  assign pop   = !render_active_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers wrap naturally because the depth is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    err_ovf_d = err_ovf_q | (cpu_wr_req_i & full);
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      wq_addr_q[wr_ptr_q] <= cpu_wr_addr_i;
      wq_data_q[wr_ptr_q] <= cpu_wr_data_i;
    end
  end

  // Read FSM next state
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_col_d  = err_col_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_rd_req_i) begin
          rd_addr_d = cpu_rd_addr_i;
          state_d   = StPend;
        end
      end
      StPend: begin
        // Waiting for an empty queue lets the read see every earlier write.
        if (!render_active_i && empty) state_d = StIssueWait;
      end
      StIssueWait: begin
        // Data for the address issued last cycle; the renderer cannot block this.
        rd_data_d  = mem_rdata_i;
        rd_valid_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (cpu_rd_req_i && (state_q != StIdle)) err_col_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= StIdle;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_col_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_ovf_q  <= err_ovf_d;
      err_col_q  <= err_col_d;
    end
  end

  // VRAM port mux; state is held at reset values during reset, so this yields
  // mem_we_o = 0 and mem_addr_o = ren_addr_i or 0 while rst_ni is low.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (render_active_i) begin
      mem_addr_o = ren_addr_i;
    end else if (!empty) begin
      mem_addr_o  = wq_addr_q[rd_ptr_q];
      mem_wdata_o = wq_data_q[rd_ptr_q];
      mem_we_o    = 1'b1;
    end else if (state_q == StPend) begin
      mem_addr_o = rd_addr_q;
    end
  end

  assign ren_rdata_o      = mem_rdata_i;
  assign cpu_wr_full_o    = full;
  assign cpu_rd_busy_o    = (state_q != StIdle);
  assign cpu_rd_valid_o   = rd_valid_q;
  assign cpu_rd_data_o    = rd_data_q;
  assign wq_level_o       = level_q;
  assign err_overflow_o   = err_ovf_q;
  assign err_rd_collide_o = err_col_q;

endmodule
